// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   state_t     - debounce FSM states
//   frame_cls_t - classification of one complete 16-key scan frame
//   frame_res_t - classification plus the key code when exactly one key is seen
//   classify()  - reduce a 16-bit frame (bit index = row*4+col) to frame_res_t
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_ONE   = 2'd1,
        FR_MULTI = 2'd2
    } frame_cls_t;

    typedef struct packed {
        frame_cls_t cls;
        logic [3:0] code;
    } frame_res_t;

    function automatic frame_res_t classify(input logic [NUM_ROWS*NUM_COLS-1:0] f);
        frame_res_t r;
        logic [4:0] n;
        n      = '0;
        r.code = '0;
        for (int i = 0; i < NUM_ROWS*NUM_COLS; i++) begin
            if (f[i]) begin
                n      = n + 5'd1;
                r.code = 4'(i);
            end
        end
        if (n == 5'd0)      r.cls = FR_NONE;
        else if (n == 5'd1) r.cls = FR_ONE;
        else                r.cls = FR_MULTI;
        return r;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a W-bit bus, async active-low reset.
//   clk, rst_n - clock / reset
//   d          - asynchronous input
//   q          - synchronized output (2 cycles of latency)
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix, debounces whole frames
// and hands out one key code per press through a valid/ready handshake.
//   clk, rst_n   - clock / async active-low reset
//   cols         - column drive, active-low, one column at a time
//   rows         - row sense, active-low, asynchronous
//   key_code     - accepted key (row*4+col)
//   key_valid    - key_code holds an unconsumed key
//   key_ready    - consumer takes key_code when key_valid & key_ready
//   overrun      - sticky: a key was accepted over an unconsumed one
//   overrun_clr  - clears overrun
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] cols,
    input  logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overrun,
    input  logic       overrun_clr
);

    localparam int         CW    = $clog2(SCAN_DIV);
    localparam logic [3:0] DEB_W = 4'(DEB_FRAMES);

    // ---------------- column scan ----------------
    // run is 0 in reset and goes high on the first edge afterwards, so the
    // columns stay released until that edge and column 0 then gets a full dwell.
    logic          run;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          sample;
    logic          frame_done;

    assign sample     = run && (cnt == CW'(SCAN_DIV - 1));
    assign frame_done = sample && (idx == 2'd3);
    assign cols       = run ? ~(4'b0001 << idx) : 4'hF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
            idx <= '0;
        end else begin
            run <= 1'b1;
            if (run) begin
                if (sample) begin
                    cnt <= '0;
                    idx <= idx + 2'd1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // ---------------- row sampling ----------------
    logic [3:0] rows_s;

    sync2 #(.W(NUM_ROWS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rows),
        .q     (rows_s)
    );

    // frame_full merges the live column sample into the stored frame so the
    // classification sees all 16 bits on the edge that completes the frame.
    logic [NUM_ROWS*NUM_COLS-1:0] frame_q;
    logic [NUM_ROWS*NUM_COLS-1:0] frame_full;

    always_comb begin
        frame_full = frame_q;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (2'(c) == idx) frame_full[r*NUM_COLS + c] = ~rows_s[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      frame_q <= '0;
        else if (sample) frame_q <= frame_full;
    end

    // ---------------- debounce FSM ----------------
    state_t     state, state_n;
    logic [3:0] cand, cand_n;
    logic [3:0] deb, deb_n;
    logic       accept;
    frame_res_t res;

    assign res = classify(frame_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= '0;
            deb   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            deb   <= deb_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        deb_n   = deb;
        accept  = 1'b0;
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (res.cls == FR_ONE) begin
                        cand_n = res.code;
                        deb_n  = 4'd1;
                        if (DEB_W == 4'd1) begin
                            accept  = 1'b1;
                            state_n = HELD;
                        end else begin
                            state_n = PRESS_DEB;
                        end
                    end
                end
                PRESS_DEB: begin
                    if (res.cls == FR_ONE && res.code == cand) begin
                        deb_n = deb + 4'd1;
                        if (deb_n == DEB_W) begin
                            accept  = 1'b1;
                            state_n = HELD;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    // chords and ghost patterns while held are ignored
                    if (res.cls == FR_NONE) begin
                        deb_n   = 4'd1;
                        state_n = REL_DEB;
                    end
                end
                REL_DEB: begin
                    if (res.cls == FR_NONE) begin
                        deb_n = deb + 4'd1;
                        // >= so a one-frame debounce still leaves this state
                        if (deb_n >= DEB_W) state_n = IDLE;
                    end else begin
                        state_n = HELD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // ---------------- output handshake ----------------
    // An accept beats a same-cycle handshake; overrun only counts when the
    // previous key is being overwritten without having been taken.
    logic ov_set;
    assign ov_set = accept && key_valid && !key_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                key_code  <= cand_n;
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
            if (ov_set)           overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed + randomized bench for keypad_scanner with
// SCAN_DIV=4, DEB_FRAMES=2. A physical key-matrix model drives rows from the
// pressed set and cols; a frame-level reference model predicts the outputs.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DF = 2;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cols, rows, key_code;
    logic        key_valid, overrun;
    logic        key_ready = 1'b0;
    logic        overrun_clr = 1'b0;
    logic [15:0] pressed = '0;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         e = 0;          // edges since reset release
    bit         m_armed = 1'b1; // no key currently held
    int         m_run = 0;      // matching press frames seen
    int         m_rel = 0;      // empty frames seen while held
    logic [3:0] m_cand = '0;
    logic       m_kv = 1'b0;
    logic [3:0] m_code = '0;
    logic       m_ov = 1'b0;

    int   dut_acc = 0;
    logic prev_kv = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEB_FRAMES(DF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cols        (cols),
        .rows        (rows),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    // key matrix: a pressed key shorts its row to its column
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4 + c] && !cols[c]) rows[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        e = 0; m_armed = 1'b1; m_run = 0; m_rel = 0; m_cand = '0;
        m_kv = 1'b0; m_code = '0; m_ov = 1'b0;
    endtask

    // one complete frame with the current pressed set
    task automatic model_frame(output bit acc);
        int n;
        logic [3:0] c;
        acc = 1'b0;
        n = $countones(pressed);
        c = '0;
        for (int i = 0; i < 16; i++) if (pressed[i]) c = 4'(i);
        if (m_armed) begin
            if (n == 1) begin
                if (m_run > 0 && c != m_cand) begin
                    m_run = 0;
                end else begin
                    if (m_run == 0) m_cand = c;
                    m_run++;
                    if (m_run == DF) begin
                        acc = 1'b1; m_armed = 1'b0; m_run = 0; m_rel = 0;
                    end
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (n == 0) begin
                m_rel++;
                if (m_rel == DF) begin m_armed = 1'b1; m_rel = 0; end
            end else begin
                m_rel = 0;
            end
        end
    endtask

    function automatic logic [3:0] exp_cols(input int ed);
        logic [3:0] one;
        one = 4'b0001;
        if (ed == 0) return 4'hF;
        return ~(one << (((ed - 1) / SD) % 4));
    endfunction

    task automatic tick();
        bit acc, hs, ovs;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            e++;
            acc = 1'b0;
            if (e > 1 && (e - 1) % FR == 0) model_frame(acc);
            hs  = m_kv && key_ready;
            ovs = acc && m_kv && !key_ready;
            if (acc)     begin m_code = m_cand; m_kv = 1'b1; end
            else if (hs) m_kv = 1'b0;
            if (ovs)              m_ov = 1'b1;
            else if (overrun_clr) m_ov = 1'b0;
        end
        #1;
        chk("key_valid", 16'(key_valid), 16'(m_kv));
        chk("key_code", 16'(key_code), 16'(m_code));
        chk("overrun", 16'(overrun), 16'(m_ov));
        chk("cols_rot", 16'(cols), 16'(exp_cols(e)));
        chk("cols_onehot", 16'($countones(~cols) <= 1), 16'd1);
        if (key_valid && !prev_kv) dut_acc++;
        prev_kv = key_valid;
    endtask

    task automatic run(input int n, input bit rnd);
        repeat (n) begin
            if (rnd) begin
                key_ready   = ($urandom_range(0, 3) == 0);
                overrun_clr = ($urandom_range(0, 15) == 0);
            end
            tick();
        end
    endtask

    initial begin
        int a0;
        int k;
        logic [15:0] one16;
        one16 = 16'd1;

        // reset state
        repeat (3) tick();
        rst_n = 1'b1;
        tick();                               // column 0 on first edge

        // hold key 9 (row 2, col 1) for 5 frames
        a0 = dut_acc;
        pressed = one16 << 9;
        run(2*FR, 1'b0);
        chk("A_valid", 16'(key_valid), 16'd1);
        chk("A_code", 16'(key_code), 16'd9);
        key_ready = 1'b1;
        tick();
        chk("A_clear", 16'(key_valid), 16'd0);
        run(3*FR - 1, 1'b0);
        pressed = '0;
        run(3*FR, 1'b0);
        chk("A_count", 16'(dut_acc - a0), 16'd1);

        // key 5 for a single frame
        a0 = dut_acc;
        pressed = one16 << 5;
        run(FR, 1'b0);
        pressed = '0;
        run(3*FR, 1'b0);
        chk("B_count", 16'(dut_acc - a0), 16'd0);

        // chord 0+15, then 3 followed by 3+7
        a0 = dut_acc;
        pressed = (one16 << 0) | (one16 << 15);
        run(3*FR, 1'b0);
        pressed = '0;
        run(2*FR, 1'b0);
        chk("C_multi", 16'(dut_acc - a0), 16'd0);
        pressed = one16 << 3;
        run(2*FR, 1'b0);
        chk("C_code3", 16'(key_code), 16'd3);
        pressed = pressed | (one16 << 7);
        run(3*FR, 1'b0);
        pressed = '0;
        run(2*FR, 1'b0);
        chk("C_count", 16'(dut_acc - a0), 16'd1);

        // overrun: 4 not consumed, then 6
        key_ready = 1'b0;
        pressed = one16 << 4;
        run(2*FR, 1'b0);
        chk("D_code4", 16'(key_code), 16'd4);
        chk("D_ov0", 16'(overrun), 16'd0);
        pressed = '0;
        run(2*FR, 1'b0);
        pressed = one16 << 6;
        run(2*FR, 1'b0);
        chk("D_code6", 16'(key_code), 16'd6);
        chk("D_ov1", 16'(overrun), 16'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("D_ovclr", 16'(overrun), 16'd0);
        key_ready = 1'b1;
        tick();
        chk("D_taken", 16'(key_valid), 16'd0);
        run(FR - 2, 1'b0);
        pressed = '0;
        run(2*FR, 1'b0);

        // reset during PRESS_DEB of key 12
        pressed = one16 << 12;
        run(FR + 8, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("E_cols", 16'(cols), 16'hF);
        chk("E_valid", 16'(key_valid), 16'd0);
        chk("E_code", 16'(key_code), 16'd0);
        model_reset();
        pressed = '0;
        tick();
        tick();
        rst_n = 1'b1;
        a0 = dut_acc;
        tick();
        chk("E_col0", 16'(cols), 16'hE);
        run(3*FR, 1'b0);
        chk("E_nostale", 16'(dut_acc - a0), 16'd0);

        // randomized key sets and handshake
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 3);
            if (k == 0)      pressed = '0;
            else if (k < 3)  pressed = one16 << $urandom_range(0, 15);
            else             pressed = (one16 << $urandom_range(0, 15)) |
                                       (one16 << $urandom_range(0, 15));
            run(FR * $urandom_range(1, 3), 1'b1);
        end
        key_ready = 1'b1;
        overrun_clr = 1'b0;
        pressed = '0;
        run(3*FR, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
